// File: rtl/bit_population_generator.sv
// bit_population_generator
//
// Builds a WIDTH-bit word that holds exactly N ones, or as many as the
// mask allows. The ones go at the lowest-indexed set positions of a
// position mask. The scan examines one bit per clock.
//
// A request is accepted with a ready/valid handshake. The result is
// announced with a one-cycle strobe.
//
// Ports:
//   clk_i       clock
//   rst_n_i     asynchronous active-low reset
//   data_val_i  request valid (only taken while ready_o=1)
//   data_i      requested population count N (CW bits, unsigned)
//   mask_i      allowed bit positions, sampled with the request
//   ready_o     idle and able to accept a request
//   data_val_o  one-cycle result strobe
//   data_o      generated word (held until the next result)
//   count_o     number of ones actually placed
//   sat_o       N exceeded the population available in the mask
module bit_population_generator #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             data_val_i,
  input  logic [CW-1:0]    data_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             ready_o,
  output logic             data_val_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             sat_o
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    req_q, req_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    placed_q, placed_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             val_q, val_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sat_q, sat_d;

  // Contribution of the bit under examination this cycle.
  logic             take_bit;
  logic [WIDTH-1:0] scan_word;
  logic [CW-1:0]    scan_placed;

  assign take_bit    = mask_q[idx_q] && (placed_q < req_q);
  assign scan_word   = word_q | (WIDTH'(take_bit) << idx_q);
  assign scan_placed = placed_q + CW'(take_bit);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    mask_d   = mask_q;
    word_d   = word_q;
    placed_d = placed_q;
    idx_d    = idx_q;
    val_d    = 1'b0;
    dout_d   = dout_q;
    count_d  = count_q;
    sat_d    = sat_q;

    case (state_q)
      IDLE: begin
        if (data_val_i) begin
          req_d    = data_i;
          mask_d   = mask_i;
          word_d   = '0;
          placed_d = '0;
          idx_d    = '0;
          if (data_i == '0) begin
            // A zero request needs no scan: answer on the accept edge.
            val_d   = 1'b1;
            dout_d  = '0;
            count_d = '0;
            sat_d   = 1'b0;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        word_d   = scan_word;
        placed_d = scan_placed;
        idx_d    = idx_q + IW'(1);
        // Stop once the target is met, or after the last position.
        // This is the edge that publishes the result.
        if ((scan_placed == req_q) || (idx_q == IW'(WIDTH - 1))) begin
          state_d = IDLE;
          val_d   = 1'b1;
          dout_d  = scan_word;
          count_d = scan_placed;
          sat_d   = (req_q > scan_placed);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      mask_q   <= '0;
      word_q   <= '0;
      placed_q <= '0;
      idx_q    <= '0;
      val_q    <= 1'b0;
      dout_q   <= '0;
      count_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      mask_q   <= mask_d;
      word_q   <= word_d;
      placed_q <= placed_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      dout_q   <= dout_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign data_val_o = val_q;
  assign data_o     = dout_q;
  assign count_o    = count_q;
  assign sat_o      = sat_q;

endmodule

// File: doc/bit_population_generator.md
# bit_population_generator

Inverse companion of `bit_population_counter`: accepts a requested population count plus a WIDTH-bit position mask, and builds a WIDTH-bit word with exactly that many ones. The ones are placed at the lowest-indexed set positions of the mask, scanning one bit per clock.
- Used as a stimulus/pattern source for the counter.
- Its `data_o` feeds `bit_population_counter.data_i` directly in loopback checking.
- Iterative, with a ready/valid request handshake and a single-cycle result strobe.

## Interface
- `WIDTH`, 32, width of generated word and mask (≥ 2).
- `CW`, `$clog2(WIDTH)+2`, width of count buses; matches the counter's `data_o` width.

- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset. One clock; reset is asynchronous and active-low.
- `data_val_i`  in  1  request valid; accepted only when `ready_o`=1.
- `data_i`  in  CW  requested count N (any value 0..2^CW-1).
- `mask_i`  in  WIDTH  allowed bit positions; sampled with the request.
- `ready_o`  out  1  high when idle and able to accept a request.
- `data_val_o`  out  1  one-cycle strobe: result valid.
- `data_o`  out  WIDTH  generated word.
- `count_o`  out  CW  number of ones actually placed.
- `sat_o`  out  1  N exceeded the available mask population (N > `count_o`).

## Operation
- FSM has two states, IDLE and SCAN.
- `ready_o` = (state == IDLE), combinational; it is 1 during reset.
- **Accept**: a rising edge with IDLE & `data_val_i` latches `req_q`=`data_i` and `mask_q`=`mask_i`, and clears `word_q`, `placed_q` and `idx_q`.
  - If `data_i`==0: stay IDLE and pulse the result immediately (`data_o`=0, `count_o`=0, `sat_o`=0).
  - Otherwise: enter SCAN.
- **SCAN**: each edge processes bit `idx_q`.
  - If `mask_q[idx_q]` and `placed_q` < `req_q`: set `word_q[idx_q]` and increment `placed_q`.
  - Then increment `idx_q`.
- **Exit SCAN** on the edge where the updated `placed_q` == `req_q`, or where `idx_q` == WIDTH-1. That same edge:
  - returns to IDLE;
  - loads `data_o` (final word), `count_o` (final `placed_q`) and `sat_o` (`req_q` > final `placed_q`);
  - sets `data_val_o`.
- `data_val_o` is registered and high for exactly one cycle per accepted request.
- `data_o`, `count_o` and `sat_o` hold their last result until the next result; they do not change during SCAN.
- `data_val_i` while `ready_o`=0 is ignored, with no queuing and no side effects.
- Arithmetic rules:
  - `placed_q` and `count_o` are CW bits and cannot exceed WIDTH.
  - Requests with N > WIDTH are legal: they scan all WIDTH bits and report `sat_o`=1.
  - Comparisons are unsigned at CW width.
- A zero mask with N>0 scans all WIDTH bits and returns `data_o`=0, `count_o`=0, `sat_o`=1.
- **Invariant**: popcount(`data_o`) == `count_o`, and `data_o` & ~mask == 0.

## Timing
- Accept edge T.
  - N=0: `data_val_o` is high in the cycle after edge T, and `ready_o` stays 1.
  - N>0: let n = index of the N-th set mask bit + 1, or WIDTH if the mask has fewer than N set bits. `data_val_o` is high between edges T+n and T+n+1.
- `ready_o` goes low after edge T (N>0) and returns high after edge T+n.
- A new request may be accepted at edge T+n+1, concurrent with `data_val_o`. Back-to-back operation is supported.
- Worst-case latency is WIDTH+1 edges from accept to strobe.
- Asynchronous reset (`rst_n_i`=0), effective immediately, including mid-SCAN:
  - state → IDLE, `ready_o`=1;
  - `data_val_o`=0, `data_o`=0, `count_o`=0, `sat_o`=0;
  - all internal registers cleared.
  - No strobe is produced for an aborted request.
  - Requests are honoured from the first rising edge after `rst_n_i` deasserts.

## Test plan
- N=5, mask=0xFFFFFFFF -> `data_o`=0x0000001F, `count_o`=5, `sat_o`=0; strobe in the cycle after edge T+5; `ready_o` low for 5 cycles.
- N=6, mask=0xF0F0F0F0 -> `data_o`=0x000030F0, `count_o`=6, `sat_o`=0, n=14.
- N=33, mask=0xFFFF0000 -> `data_o`=0xFFFF0000, `count_o`=16, `sat_o`=1, n=32. Then N=0 -> immediate strobe with `data_o`=0 and `ready_o` never low.
- N=20, mask=all ones, with `data_val_i`=1 and N=3 held during SCAN -> the second request is ignored; a single strobe with `data_o`=0x000FFFFF. Then N=3 is accepted at edge T+21 and produces 0x00000007.
- N=32, mask=all ones, `rst_n_i` pulsed low at cycle 10 of SCAN -> all outputs 0 immediately, `ready_o`=1, no strobe. After release, N=1, mask=0x80000000 -> `data_o`=0x80000000, n=32.
- Loopback of 1000 random (N in 0..WIDTH+3, random mask):
  - `data_o` is fed to `bit_population_counter`, whose `data_o` must equal `count_o`;
  - `data_o` & ~mask == 0;
  - `sat_o` == (N > `count_o`).
